// File: rtl/systolic_ctrl.sv
// Job sequencer for the DIM x DIM systolic MAC array: clear, feed with skew drain, then row readout.
// Optional cycle counter output perf_cycles is enabled by defining SYSTOLIC_CTRL_PERF_EN.
module systolic_ctrl #(
    parameter int BITS_C = 16,
    parameter int DIM    = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    output logic                      op_rd_en,
    output logic [$clog2(DIM)-1:0]    op_rd_idx,
    output logic                      arr_en,
    output logic                      arr_wren,
    output logic [$clog2(DIM)-1:0]    arr_crow,
    input  logic [DIM*BITS_C-1:0]     arr_cout,
    output logic                      row_valid,
    input  logic                      row_ready,
    output logic [$clog2(DIM)-1:0]    row_idx,
    output logic [DIM*BITS_C-1:0]     row_data
`ifdef SYSTOLIC_CTRL_PERF_EN
    ,
    output logic [31:0]               perf_cycles
`endif
);

    localparam int IW = $clog2(DIM);
    localparam int FW = $clog2(3 * DIM);
    localparam logic [FW-1:0] FEED_LAST = FW'(3 * DIM - 2);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DIM - 1);

    typedef enum logic [1:0] {IDLE, CLEAR, FEED, READ} state_t;
    typedef enum logic {PH_CAP, PH_HOLD} phase_t;

    state_t                  state_q;
    phase_t                  phase_q;
    logic [IW-1:0]           idx_q;
    logic [FW-1:0]           feedCnt_q;
    logic [FW-1:0]           feedCnt_d;
    logic                    busy_q, done_q, opRdEn_q, arrEn_q, arrWren_q, rowValid_q;
    logic [IW-1:0]           opRdIdx_q, arrCrow_q, rowIdx_q;
    logic [DIM*BITS_C-1:0]   rowData_q;
    logic                    accept;

    // A start landing on the done cycle is still seen in IDLE, so it is masked here.
    assign accept    = (state_q == IDLE) && start && !done_q;
    assign feedCnt_d = feedCnt_q + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            phase_q    <= PH_CAP;
            idx_q      <= '0;
            feedCnt_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            opRdEn_q   <= 1'b0;
            opRdIdx_q  <= '0;
            arrEn_q    <= 1'b0;
            arrWren_q  <= 1'b0;
            arrCrow_q  <= '0;
            rowValid_q <= 1'b0;
            rowIdx_q   <= '0;
            rowData_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q   <= CLEAR;
                        busy_q    <= 1'b1;
                        arrWren_q <= 1'b1;
                        arrCrow_q <= '0;
                        idx_q     <= '0;
                    end
                end
                CLEAR: begin
                    if (idx_q == IDX_LAST) begin
                        state_q   <= FEED;
                        arrWren_q <= 1'b0;
                        arrCrow_q <= '0;
                        feedCnt_q <= '0;
                        opRdEn_q  <= 1'b1;
                        opRdIdx_q <= '0;
                    end else begin
                        idx_q     <= idx_q + 1'b1;
                        arrCrow_q <= idx_q + 1'b1;
                    end
                end
                // The array is enabled one cycle behind the read strobe to cover memory latency.
                FEED: begin
                    if (feedCnt_q == FEED_LAST) begin
                        state_q   <= READ;
                        phase_q   <= PH_CAP;
                        arrEn_q   <= 1'b0;
                        opRdEn_q  <= 1'b0;
                        opRdIdx_q <= '0;
                        arrCrow_q <= '0;
                        idx_q     <= '0;
                    end else begin
                        feedCnt_q <= feedCnt_d;
                        arrEn_q   <= 1'b1;
                        opRdEn_q  <= (feedCnt_d < FW'(DIM));
                        opRdIdx_q <= (feedCnt_d < FW'(DIM)) ? feedCnt_d[IW-1:0] : '0;
                    end
                end
                READ: begin
                    if (phase_q == PH_CAP) begin
                        rowData_q  <= arr_cout;
                        rowIdx_q   <= idx_q;
                        rowValid_q <= 1'b1;
                        phase_q    <= PH_HOLD;
                    end else if (rowValid_q && row_ready) begin
                        rowValid_q <= 1'b0;
                        phase_q    <= PH_CAP;
                        if (idx_q == IDX_LAST) begin
                            state_q   <= IDLE;
                            busy_q    <= 1'b0;
                            done_q    <= 1'b1;
                            arrCrow_q <= '0;
                            idx_q     <= '0;
                        end else begin
                            idx_q     <= idx_q + 1'b1;
                            arrCrow_q <= idx_q + 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef SYSTOLIC_CTRL_PERF_EN
    logic [31:0] perf_q;

    // The accepting cycle counts as the first busy cycle; counting stops once busy drops at done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_q <= '0;
        end else if (accept) begin
            perf_q <= 32'd1;
        end else if (busy_q && (perf_q != 32'hFFFF_FFFF)) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign perf_cycles = perf_q;
`endif

    assign busy      = busy_q;
    assign done      = done_q;
    assign op_rd_en  = opRdEn_q;
    assign op_rd_idx = opRdIdx_q;
    assign arr_en    = arrEn_q;
    assign arr_wren  = arrWren_q;
    assign arr_crow  = arrCrow_q;
    assign row_valid = rowValid_q;
    assign row_idx   = rowIdx_q;
    assign row_data  = rowData_q;

endmodule

// File: doc/systolic_ctrl.md
Name: systolic_ctrl

Overview:
- Job sequencer for the DIM x DIM signed MAC systolic array, sitting between the host command interface and the array.
- One `start` pulse runs a full job: clear all C accumulators, stream DIM operand vectors with the pipeline-fill drain, then read the DIM result rows out over a valid/ready handshake.
- The array's Cin bus is tied to zero at the top level, so CLEAR writes zeros.
- Operand memories with built-in row/column skew are external; this block supplies their read strobe and index.

Parameters:
- BITS_C, 16, width of one accumulator/result element.
- DIM, 8, array dimension (rows = columns = operand vector count).

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  job request; sampled only in IDLE.
- busy  output  1  high while a job is in progress.
- done  output  1  one-cycle pulse when the job completes.
- op_rd_en  output  1  read strobe to the skewed A/B operand memories.
- op_rd_idx  output  $clog2(DIM)  operand vector index k.
- arr_en  output  1  array MAC/shift enable.
- arr_wren  output  1  array C-row write enable.
- arr_crow  output  $clog2(DIM)  array C row select (write and read).
- arr_cout  input  DIM*BITS_C  selected array row, packed; element c at bits [c*BITS_C +: BITS_C].
- row_valid  output  1  row_data holds a result row.
- row_ready  input  1  consumer accepts the row.
- row_idx  output  $clog2(DIM)  row number of row_data.
- row_data  output  DIM*BITS_C  registered result row.

Behaviour:
- Reset values: all outputs 0; state IDLE.
- A reset mid-job aborts immediately, with no done pulse.
- Every output is registered.
- States: IDLE -> CLEAR -> FEED -> READ -> IDLE.
- IDLE:
  - busy=0.
  - start=1 -> CLEAR on the next edge; busy rises that edge.
  - start while busy is ignored; it is not queued.
- CLEAR:
  - DIM cycles with arr_wren=1, arr_en=0, arr_crow=0..DIM-1.
  - Then FEED.
- FEED:
  - 3*DIM-1 cycles, counted by feed_cnt = 0..3*DIM-2.
  - op_rd_en=1 and op_rd_idx=feed_cnt for feed_cnt < DIM; otherwise op_rd_en=0 and op_rd_idx=0.
  - arr_en=1 for feed_cnt >= 1, giving 3*DIM-2 enabled cycles: operand memory read latency is 1 cycle, and skew drain is 2*(DIM-1).
  - Feeding zeros after the last vector is the memory's job; this block only holds rd_en low.
  - Then READ with r=0.
- READ, per row r:
  - Phase SEL (1 cycle): arr_crow=r.
  - Phase CAP: row_data<=arr_cout, row_idx<=r, row_valid<=1.
  - Then hold: row_valid and row_data are stable until row_valid & row_ready.
  - On handshake: row_valid drops the next cycle unless the next row is loading; SEL for r+1 starts in the same cycle.
  - Maximum throughput is one row per 2 cycles.
  - row_ready high before row_valid is harmless.
  - After the row DIM-1 handshake: done=1 for one cycle, busy=0 on that same edge, and the FSM returns to IDLE.
  - start on the done cycle is not accepted.
- arr_en and arr_wren are never high together.
- arr_crow is 0 outside CLEAR/READ.
- Counters are exactly $clog2(DIM) bits, with terminal compare at DIM-1, so there is no wrap-around into an extra row.

Optional Feature:
- SYSTOLIC_CTRL_PERF_EN defined:
  - Adds output perf_cycles [31:0], reset 0.
  - It counts the cycles in which busy=1, including row_ready stalls.
  - It clears on start acceptance and freezes at done.
  - The count saturates at 32'hFFFF_FFFF.
- Not defined: the port and counter are absent; behaviour is otherwise identical.

Test Plan:
- Reset/idle (DIM=8): assert rst mid-cycle -> all outputs 0 asynchronously; with no start for 20 cycles -> busy=0 and arr_en/arr_wren=0.
- Single job, row_ready tied 1:
  - start at cycle 0 -> arr_wren high cycles 1-8 with arr_crow 0..7.
  - op_rd_en high cycles 9-16 with idx 0..7; arr_en high cycles 10-31.
  - 8 rows, each row_data equal to the arr_cout model value for its row_idx.
  - done pulse at cycle 48.
- Backpressure: row_ready low for 5 cycles while row 3 is valid -> row_data/row_idx=3 held stable; done delayed by exactly 5 cycles.
- Ignored start: pulse start during FEED and on the done cycle -> no second job; busy falls after done.
- Abort: rst pulse at FEED cycle 5 -> IDLE, no done; a new start runs a clean job with correct results (A=identity, B=k -> rows equal B).
- SYSTOLIC_CTRL_PERF_EN: job from scenario 2 -> perf_cycles=48; scenario 3 -> 53.
